// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer that shares one external combinational ALU
// among NUM_REQ requesters. One request is accepted at a time. Its operands are
// registered and drive the ALU. The ALU result is captured one cycle later and
// returned on a single tagged response port that supports backpressure.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (at most one ready bit high)
//   req_op/req_a/req_b    per-requester op (4 bits) and operands, slice i = requester i
//   alu_op/alu_a/alu_b    registered op and operands driven to the shared ALU
//   alu_x                 combinational result returned by the shared ALU
//   resp_valid/resp_ready response handshake
//   resp_id/resp_data     owning requester index and captured result
//   resp_err              illegal-op flag
//
// Optional feature macro: ALU_ARBITER_ILLEGAL_OP_EN
//   When defined, an accepted op encoding >= 10 returns resp_err=1 and resp_data=0.
//   When undefined, resp_err is tied 0 and every op is passed straight through.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*4-1:0]       req_op,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [3:0]                 alu_op,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  input  logic [WIDTH-1:0]           alu_x,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       resp_err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   scanIdx;
  logic             anyValid;
  logic             accept;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] respData_q;
  logic [IDW-1:0]   respId_q;
  logic [WIDTH-1:0] captureData;

  logic [3:0]       opArr [NUM_REQ];
  logic [WIDTH-1:0] aArr  [NUM_REQ];
  logic [WIDTH-1:0] bArr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opArr[gi] = req_op[gi*4 +: 4];
    assign aArr[gi]  = req_a[gi*WIDTH +: WIDTH];
    assign bArr[gi]  = req_b[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: the first valid requester at or above ptr_q, wrapping
  // around, wins the grant.
  always_comb begin
    grant    = ptr_q;
    anyValid = 1'b0;
    scanIdx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!anyValid && req_valid[scanIdx]) begin
        anyValid = 1'b1;
        grant    = scanIdx;
      end
    end
  end

  // Next-state and handshake outputs. req_ready is gated with rst_n so that it
  // reads as 0 for the whole time reset is held, even if requesters stay valid.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (anyValid && rst_n) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          ptr_d            = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state_d          = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and response registers. The operands change only
  // on accept. The response is captured only on the EXEC edge, so it holds
  // steady through any backpressure in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      respData_q <= '0;
      respId_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        op_q <= opArr[grant];
        a_q  <= aArr[grant];
        b_q  <= bArr[grant];
        id_q <= grant;
      end
      if (state_q == EXEC) begin
        respData_q <= captureData;
        respId_q   <= id_q;
      end
    end
  end

`ifdef ALU_ARBITER_ILLEGAL_OP_EN
  logic illegalOp;
  logic respErr_q;

  // Encodings above SRA (9) are not ALU ops. Their ALU output is discarded.
  assign illegalOp   = (op_q >= 4'd10);
  assign captureData = illegalOp ? '0 : alu_x;

  // The error flag is captured on the same EXEC edge as the response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respErr_q <= 1'b0;
    end else if (state_q == EXEC) begin
      respErr_q <= illegalOp;
    end
  end

  assign resp_err = respErr_q;
`else
  assign captureData = alu_x;
  assign resp_err    = 1'b0;
`endif

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign resp_id   = respId_q;
  assign resp_data = respData_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural ALU stands in for the
// shared ALU. Expected grants come from a round-robin pointer model, and
// expected results come from the payload each requester presented.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [W-1:0]      alu_x;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_data;
  logic              resp_err;

  int checkCount = 0;
  int failCount  = 0;
  int cycleCount = 0;
  int modelPtr   = 0;
  int lastAcceptCycle = 0;
  int prevAcceptCycle = 0;

  bit           vValid [NREQ];
  logic [3:0]   vOp    [NREQ];
  logic [W-1:0] vA     [NREQ];
  logic [W-1:0] vB     [NREQ];

  logic [W-1:0] lastData;
  logic [1:0]   lastId;
  logic         lastErr;

  alu_arbiter #(.NUM_REQ(NREQ), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_x      (alu_x),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure spacing between accepts
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural shared ALU: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA, other
  // encodings give a recognisable garbage value
  function automatic logic [W-1:0] aluRef(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return W'($signed(a) >>> b[4:0]);
      default: return a ^ b ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  always_comb alu_x = aluRef(alu_op, alu_a, alu_b);

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one requester's slot and remember what it presents
  task automatic applyStimulus(input int i, input bit v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vValid[i] = v;
    vOp[i]    = op;
    vA[i]     = a;
    vB[i]     = b;
    req_valid[i]        = v;
    req_op[i*4 +: 4]    = op;
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
  endtask

  function automatic logic [W-1:0] randData();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic newRandomRequest(input int i);
    logic [3:0] op;
    op = ($urandom % 8 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
    applyStimulus(i, 1'b1, op, randData(), randData());
  endtask

  task automatic dropRequest(input int i);
    applyStimulus(i, 1'b0, vOp[i], vA[i], vB[i]);
  endtask

  // Round-robin reference: first valid requester at or after the pointer
  function automatic int expectedGrant();
    int g;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && vValid[(modelPtr + k) % NREQ]) g = (modelPtr + k) % NREQ;
    end
    return g;
  endfunction

  function automatic bit noneValid();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) any |= vValid[i];
    return !any;
  endfunction

  task automatic checkResetValues(input string p);
    checkOutput({p, "Ready"},     req_ready, 0);
    checkOutput({p, "AluOp"},     alu_op, 0);
    checkOutput({p, "AluA"},      alu_a, 0);
    checkOutput({p, "AluB"},      alu_b, 0);
    checkOutput({p, "RespValid"}, resp_valid, 0);
    checkOutput({p, "RespId"},    resp_id, 0);
    checkOutput({p, "RespData"},  resp_data, 0);
    checkOutput({p, "RespErr"},   resp_err, 0);
  endtask

  // One full request/response exchange starting just after a clock edge with
  // the arbiter idle. hold = cycles resp_ready stays low in RESP.
  // refill: 0 = winner drops valid, 1 = winner issues a new request, 2 = random.
  task automatic runTransaction(input int hold, input int refill);
    int           g;
    logic [3:0]   eOp;
    logic [W-1:0] eA, eB, eData;
    logic         eErr;
    resp_ready = (hold == 0);
    #1;
    g = expectedGrant();
    if (g < 0) begin
      checkOutput("noGrant", req_ready, 0);
      return;
    end
    checkOutput("grant", req_ready, NREQ'(1) << g);
    eOp = vOp[g];
    eA  = vA[g];
    eB  = vB[g];
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    eErr  = (eOp >= 4'd10);
    eData = eErr ? '0 : aluRef(eOp, eA, eB);
`else
    eErr  = 1'b0;
    eData = aluRef(eOp, eA, eB);
`endif
    @(posedge clk); #1;
    lastAcceptCycle = cycleCount;
    modelPtr = (g + 1) % NREQ;
    if (refill == 1 || (refill == 2 && ($urandom % 2) == 1)) newRandomRequest(g);
    else dropRequest(g);
    #1;
    checkOutput("execReady", req_ready, 0);
    checkOutput("execValid", resp_valid, 0);
    checkOutput("aluOp", alu_op, eOp);
    checkOutput("aluA", alu_a, eA);
    checkOutput("aluB", alu_b, eB);
    @(posedge clk); #1;
    checkOutput("respValid", resp_valid, 1);
    checkOutput("respId", resp_id, g);
    checkOutput("respData", resp_data, eData);
    checkOutput("respErr", resp_err, eErr);
    lastData = resp_data;
    lastId   = resp_id;
    lastErr  = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("stallValid", resp_valid, 1);
      checkOutput("stallData", resp_data, eData);
      checkOutput("stallId", resp_id, g);
      checkOutput("stallReady", req_ready, 0);
      if (h == hold - 1) resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("respDone", resp_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    lastData   = '0;
    lastId     = '0;
    lastErr    = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 4'd0, '0, '0);

    #3;
    checkResetValues("init");
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] round-robin with all requesters valid");
    for (int i = 0; i < NREQ; i++) newRandomRequest(i);
    for (int t = 0; t < 5; t++) begin
      runTransaction(0, 1);
      checkOutput("rrOrder", lastId, t % NREQ);
      if (t > 0) checkOutput("rrSpacing", 64'(lastAcceptCycle - prevAcceptCycle), 3);
      prevAcceptCycle = lastAcceptCycle;
    end
    for (int i = 0; i < NREQ; i++) dropRequest(i);

    $display("[TB] directed operations");
    applyStimulus(2, 1'b1, 4'd1, 32'd5, 32'd7);
    runTransaction(0, 0);
    checkOutput("subId", lastId, 2);
    checkOutput("subData", lastData, 32'hFFFF_FFFE);
    checkOutput("subErr", lastErr, 0);

    applyStimulus(0, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1);
    runTransaction(0, 0);
    checkOutput("sltData", lastData, 1);
    applyStimulus(0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1);
    runTransaction(0, 0);
    checkOutput("sltuData", lastData, 0);

    applyStimulus(3, 1'b1, 4'd0, 32'd100, 32'd23);
    runTransaction(5, 0);
    checkOutput("stallResult", lastData, 123);

    applyStimulus(1, 1'b1, 4'd12, 32'h1234, 32'h5678);
    runTransaction(0, 0);
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    checkOutput("illegalErr", lastErr, 1);
    checkOutput("illegalData", lastData, 0);
`else
    checkOutput("illegalErr", lastErr, 0);
    checkOutput("illegalData", lastData, 32'h1234 ^ 32'h5678 ^ 32'hA5A5_5A5A);
`endif

    $display("[TB] reset during EXEC");
    applyStimulus(1, 1'b1, 4'd0, 32'd1, 32'd2);
    resp_ready = 1'b1;
    #1;
    checkOutput("rstPreGrant", req_ready, 4'b0010);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) newRandomRequest(i);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("midRst");
    @(posedge clk); #1;
    checkOutput("midRstNoResp", resp_valid, 0);
    rst_n    = 1'b1;
    modelPtr = 0;
    @(posedge clk); #1;
    modelPtr = 1;
    checkOutput("postRstNoResp", resp_valid, 0);
    checkOutput("postRstAluA", alu_a, vA[0]);
    // The first post-reset accept already happened at that edge; finish it
    @(posedge clk); #1;
    checkOutput("postRstId", resp_id, 0);
    checkOutput("postRstValid", resp_valid, 1);
    @(posedge clk); #1;
    checkOutput("postRstDone", resp_valid, 0);
    newRandomRequest(0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vValid[i]) begin
          if (($urandom % 2) == 1) newRandomRequest(i);
        end else if (($urandom % 10) == 0) begin
          dropRequest(i);
        end
      end
      if (it % 25 == 0) for (int i = 0; i < NREQ; i++) dropRequest(i);
      if (noneValid()) begin
        #1;
        checkOutput("idleReady", req_ready, 0);
        @(posedge clk); #1;
        checkOutput("idleValid", resp_valid, 0);
        checkOutput("idleReady2", req_ready, 0);
        newRandomRequest(int'($urandom % NREQ));
      end
      runTransaction(int'($urandom % 3), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational ALU (`alu_pkg::Op` operations ADD..SRA on `UbitData` operands) among `NUM_REQ` requesters. Each requester presents an op and two operands on a valid/ready port. The block grants one request at a time, drives the ALU from registered operands, captures the result and returns it on a single tagged response port with backpressure. It sits between the requesting units and the shared ALU instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand/result width; must equal `UbitData` width.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input NUM_REQ: per-requester request valid.
- `req_ready` output NUM_REQ: per-requester accept; at most one bit high.
- `req_op` input NUM_REQ*4: per-requester op, `alu_pkg::Op` encoding (ADD=0..SRA=9), requester i at bits [4i+3:4i].
- `req_a` input NUM_REQ*WIDTH: per-requester operand a, requester i at slice i.
- `req_b` input NUM_REQ*WIDTH: per-requester operand b, same packing.
- `alu_op` output 4: op to shared ALU.
- `alu_a` output WIDTH: operand a to ALU.
- `alu_b` output WIDTH: operand b to ALU.
- `alu_x` input WIDTH: combinational ALU result.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: response consumer ready.
- `resp_id` output $clog2(NUM_REQ): index of the requester owning the response.
- `resp_data` output WIDTH: result.
- `resp_err` output 1: illegal-op flag; see Configuration.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: grant is the first requester with `req_valid`=1, searching upward from priority pointer `ptr` with wrap. `req_ready[grant]`=1, combinational on `req_valid`. On a handshake, the block registers op, a, b and id, sets `ptr` to (grant+1) mod NUM_REQ and goes to EXEC. With no valid request, all `req_ready`=0 and the FSM stays in IDLE.
- EXEC: `alu_*` are driven from the operand registers. They are always driven from these registers and change only on accept. At the EXEC clock edge, `alu_x` is captured into `resp_data` together with `resp_id`. Go to RESP.
- RESP: `resp_valid`=1. `resp_data`, `resp_id` and `resp_err` are held stable until `resp_ready`=1. On that handshake, go to IDLE.
- `req_ready` is 0 in EXEC and RESP. No new request is accepted until the response handshake completes.
- Requesters are round-robin fair. Reset value of `ptr` is 0.
- No arithmetic is done in this block. The ALU semantics are entirely those of the shared ALU.

## Timing
- Reset values: `req_ready`=0, `alu_op`=0 (ADD), `alu_a`=`alu_b`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `ptr`=0, state IDLE.
- Latency: request accepted at edge N → `resp_valid`=1 after edge N+1.
- Best-case throughput: one op per 3 cycles, with `resp_ready` held 1.
- Simultaneous valids: only the pointer winner is accepted. Losers must hold valid and payload stable until accepted.
- A requester dropping `req_valid` before acceptance is legal. It loses its turn with no side effect.
- `resp_ready` low: the block stays in RESP indefinitely and accepts nothing.
- Reset mid-operation, in EXEC or RESP: the in-flight result is discarded, all outputs go to reset values immediately, and `ptr` returns to 0.

## Configuration
- `ALU_ARBITER_ILLEGAL_OP_EN` defined:
  - An accepted op with encoding ≥10 sets `resp_err`=1 and `resp_data`=0 in RESP. `alu_x` is ignored for that op.
  - Latency is unchanged.
- `ALU_ARBITER_ILLEGAL_OP_EN` undefined:
  - `resp_err` is tied 0.
  - Every op is passed through and `resp_data` = `alu_x`.

## Test plan
- Single request from requester 2, SUB, a=5, b=7, `resp_ready`=1 → response one cycle after EXEC with `resp_id`=2, `resp_data`=0xFFFFFFFE, `resp_err`=0.
- SLT a=0xFFFFFFFF b=1 → `resp_data`=1; SLTU with the same operands → `resp_data`=0.
- All 4 `req_valid` held high continuously → grant order 0,1,2,3,0, each separated by 3 cycles.
- `resp_ready` held low for 5 cycles in RESP:
  - `resp_valid`, `resp_data` and `resp_id` stay stable.
  - All `req_ready` stay 0.
  - The response completes on the cycle `resp_ready` rises.
- `rst_n` asserted during EXEC:
  - All outputs return to reset values asynchronously.
  - No response is produced.
  - After release, requester 0 wins first.
- With `ALU_ARBITER_ILLEGAL_OP_EN`, op=12 → `resp_err`=1, `resp_data`=0. Without the macro, the same stimulus → `resp_err`=0, `resp_data`=`alu_x`.
